// File: rtl/fila_arb_pkg.sv
// fila_arb shared types and constants.
// States, grant encoding and count width for the fila front end.
package fila_arb_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_ISSUE,
    POP_WAIT,
    POP_CAPT
  } state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_t;

endpackage

// File: rtl/fila_arb_if.sv
// Producer/consumer and fila-side bundle for fila_arb.
// master = environment (producers, consumer, queue); slave = arbiter.
interface fila_arb_if #(
  parameter int DATA_W = 8
) ();
  import fila_arb_pkg::*;

  logic              push_req_a;
  logic [DATA_W-1:0] push_data_a;
  logic              push_ack_a;
  logic              push_req_b;
  logic [DATA_W-1:0] push_data_b;
  logic              push_ack_b;
  logic              pop_req;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              q_enqueue;
  logic              q_dequeue;
  logic [DATA_W-1:0] q_data;
  logic [DATA_W-1:0] q_rdata;
  logic [CNT_W-1:0]  q_len;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output push_req_a, push_data_a,
    output push_req_b, push_data_b,
    output pop_req, q_rdata, q_len,
    input  push_ack_a, push_ack_b,
    input  pop_valid, pop_data,
    input  q_enqueue, q_dequeue, q_data,
    input  count, full, empty
  );

  modport slave (
    input  push_req_a, push_data_a,
    input  push_req_b, push_data_b,
    input  pop_req, q_rdata, q_len,
    output push_ack_a, push_ack_b,
    output pop_valid, pop_data,
    output q_enqueue, q_dequeue, q_data,
    output count, full, empty
  );

endinterface

// File: rtl/fila_arb_rr.sv
// fila_rr_arb: 2-way round-robin picker.
// On contention the side opposite last wins; a lone requester wins.
module fila_rr_arb
  import fila_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last,
  output grant_t     grant
);

  // Pick the producer that gets the next push slot.
  always_comb begin
    grant = GRANT_A;
    unique case (1'b1)
      (req == 2'b11):
        grant = (last == GRANT_A) ? GRANT_B : GRANT_A;
      (req == 2'b10):
        grant = GRANT_B;
      default:
        grant = GRANT_A;
    endcase
  end

endmodule

// File: rtl/fila_arb.sv
// fila_arb: serialising push/pop front end for the fila queue.
// Optional FILA_ARB_CHECK_EN adds a sticky len_err vs q_len.
module fila_arb
  import fila_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int POP_FIRST = 1
) (
  input  logic clk_10KHz,
  input  logic reset,
`ifdef FILA_ARB_CHECK_EN
  output logic len_err,
`endif
  fila_arb_if.slave bus
);

  localparam bit PF = (POP_FIRST != 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  grant_t            rr_last, gnt, pick;
  logic [DATA_W-1:0] data_r, pop_r;
  logic              tie_pop;
  logic [1:0]        req;
  logic              full_w, empty_w;
  logic              push_ok, pop_ok, take_pop;

  assign req     = {bus.push_req_b, bus.push_req_a};
  assign full_w  = (cnt == CNT_W'(DEPTH));
  assign empty_w = (cnt == '0);
  assign push_ok = (|req) & ~full_w;
  assign pop_ok  = bus.pop_req & ~empty_w;
  assign take_pop = pop_ok & (~push_ok | PF | tie_pop);

  fila_rr_arb u_rr (
    .req   (req),
    .last  (rr_last),
    .grant (pick)
  );

  // Next state: one queue operation in flight at a time.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (take_pop)     state_n = POP_ISSUE;
        else if (push_ok) state_n = PUSH;
      end
      PUSH:      state_n = IDLE;
      POP_ISSUE: state_n = POP_WAIT;
      POP_WAIT:  state_n = POP_CAPT;
      POP_CAPT:  state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // State, occupancy, grant latch and captured pop word.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_last <= GRANT_B;
      gnt     <= GRANT_A;
      data_r  <= '0;
      pop_r   <= '0;
      tie_pop <= 1'b1;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (state_n == PUSH) begin
            gnt    <= pick;
            data_r <= (pick == GRANT_B) ?
                      bus.push_data_b : bus.push_data_a;
          end
          if (push_ok & pop_ok)
            tie_pop <= ~take_pop;
        end
        PUSH: begin
          cnt     <= cnt + 1'b1;
          rr_last <= gnt;
        end
        POP_CAPT: begin
          cnt   <= cnt - 1'b1;
          pop_r <= bus.q_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.q_enqueue  = (state == PUSH);
  assign bus.q_dequeue  = (state == POP_ISSUE);
  assign bus.q_data     = data_r;
  assign bus.push_ack_a = (state == PUSH) & (gnt == GRANT_A);
  assign bus.push_ack_b = (state == PUSH) & (gnt == GRANT_B);
  assign bus.pop_valid  = (state == POP_CAPT);
  assign bus.pop_data   = bus.pop_valid ? bus.q_rdata : pop_r;
  assign bus.count      = cnt;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;

`ifdef FILA_ARB_CHECK_EN
  logic idle_prev;

  // q_len lags a cycle, so compare only after two idle cycles.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      idle_prev <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      idle_prev <= (state == IDLE);
      if ((state == IDLE) && idle_prev && (bus.q_len != cnt))
        len_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fila_arb.sv
// Self-checking bench for fila_arb with a behavioural fila queue.
// Vector table, corner sequences, then random traffic vs scoreboard.
module tb_fila_arb;
  import fila_arb_pkg::*;

  logic clk_10KHz = 1'b0;
  logic reset = 1'b0;
  always #5 clk_10KHz = ~clk_10KHz;

  fila_arb_if #(.DATA_W(8)) bus ();
`ifdef FILA_ARB_CHECK_EN
  logic len_err;
`endif

  fila_arb #(.DATA_W(8), .DEPTH(8), .POP_FIRST(1)) dut (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
`ifdef FILA_ARB_CHECK_EN
    .len_err   (len_err),
`endif
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Behavioural fila: 2-cycle dequeue latency, len one cycle late.
  logic [7:0] fq[$];
  logic [7:0] pend;
  logic       deq_seen;
  always @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      fq.delete();
      pend        <= '0;
      deq_seen    <= 1'b0;
      bus.q_rdata <= '0;
      bus.q_len   <= '0;
    end else begin
      bus.q_len <= 4'(fq.size());
      if (bus.q_dequeue && fq.size() > 0) pend <= fq.pop_front();
      if (bus.q_enqueue) fq.push_back(bus.q_data);
      if (deq_seen) bus.q_rdata <= pend;
      deq_seen <= bus.q_dequeue;
    end
  end

  // Scoreboard: acked words must come back in order; count tracks it.
  logic [7:0] sb[$];
  logic enq_p, deq_p, deq_pp;
  always @(negedge clk_10KHz) begin
    if (!reset) begin
      sb.delete();
      enq_p  <= 1'b0;
      deq_p  <= 1'b0;
      deq_pp <= 1'b0;
    end else begin
      chk("proto",
          !(bus.q_enqueue && bus.q_dequeue) &&
          !(bus.q_enqueue && enq_p) &&
          !(bus.q_dequeue && deq_p) &&
          !(bus.q_enqueue && deq_p) &&
          ((bus.push_ack_a | bus.push_ack_b) == bus.q_enqueue) &&
          !(bus.push_ack_a && bus.push_ack_b), 1);
      chk("cnt", {bus.count, bus.full, bus.empty},
          {4'(sb.size()), sb.size() == 8, sb.size() == 0});
      chk("popv_timing", bus.pop_valid, deq_pp);
      if (bus.push_ack_a) begin
        chk("ackdata_a", bus.q_data, bus.push_data_a);
        sb.push_back(bus.q_data);
      end
      if (bus.push_ack_b) begin
        chk("ackdata_b", bus.q_data, bus.push_data_b);
        sb.push_back(bus.q_data);
      end
      if (bus.pop_valid) begin
        chk("pop_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("pop_order", bus.pop_data, sb.pop_front());
      end
`ifdef FILA_ARB_CHECK_EN
      chk("len_err", len_err, 0);
`endif
      enq_p  <= bus.q_enqueue;
      deq_p  <= bus.q_dequeue;
      deq_pp <= deq_p;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk_10KHz); #1 reset = 1'b0;
    @(negedge clk_10KHz); #1 reset = 1'b1;
  endtask

  // Latency counts the cycle the request is first presented as 1.
  task automatic push_op(input bit b, input logic [7:0] d,
                         output int lat, output logic [7:0] got);
    lat = -1;
    got = '0;
    @(negedge clk_10KHz); #1;
    if (b) begin bus.push_data_b = d; bus.push_req_b = 1'b1; end
    else   begin bus.push_data_a = d; bus.push_req_a = 1'b1; end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_10KHz);
      if (b ? bus.push_ack_b : bus.push_ack_a) begin
        lat = n + 1;
        got = bus.q_data;
        break;
      end
    end
    #1;
    if (b) bus.push_req_b = 1'b0;
    else   bus.push_req_a = 1'b0;
  endtask

  task automatic pop_op(output int lat, output logic [7:0] got);
    lat = -1;
    got = '0;
    @(negedge clk_10KHz); #1 bus.pop_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_10KHz);
      if (bus.pop_valid) begin
        lat = n + 1;
        got = bus.pop_data;
        break;
      end
    end
    #1 bus.pop_req = 1'b0;
  endtask

  typedef struct {
    int         op;
    logic [7:0] d;
    int         lat;
    logic [3:0] cnt;
  } vec_t;

  vec_t       v[6];
  int         lat, first, seen, acks, pops;
  int         a_wait, b_wait, maxw;
  bit         a_busy, b_busy, p_busy;
  logic [7:0] got;
  int         who[4];
  logic [7:0] dat[4];

  initial begin
    // op: 0 push A, 1 push B, 2 pop (d = expected word)
    v[0] = '{0, 8'h3C, 2, 4'd1};
    v[1] = '{1, 8'h77, 2, 4'd2};
    v[2] = '{2, 8'h3C, 4, 4'd1};
    v[3] = '{0, 8'hA5, 2, 4'd2};
    v[4] = '{2, 8'h77, 4, 4'd1};
    v[5] = '{2, 8'hA5, 4, 4'd0};

    bus.push_req_a = 0; bus.push_data_a = 0;
    bus.push_req_b = 0; bus.push_data_b = 0;
    bus.pop_req = 0;

    repeat (2) @(negedge clk_10KHz);
    chk("reset_state",
        {bus.push_ack_a, bus.push_ack_b, bus.pop_valid,
         bus.q_enqueue, bus.q_dequeue, bus.full, bus.empty,
         bus.pop_data, bus.q_data, bus.count},
        {6'b0, 1'b1, 20'b0});
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (v[i].op < 2) push_op(v[i].op == 1, v[i].d, lat, got);
      else             pop_op(lat, got);
      chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
      chk($sformatf("vec%0d_data", i), got, v[i].d);
      @(negedge clk_10KHz);
      chk($sformatf("vec%0d_count", i), {bus.count, bus.empty},
          {v[i].cnt, v[i].cnt == 0});
    end

    // Contention from reset: A first, then strict alternation.
    @(negedge clk_10KHz); #1 reset = 1'b0;
    bus.push_data_a = 8'h11; bus.push_req_a = 1'b1;
    bus.push_data_b = 8'h22; bus.push_req_b = 1'b1;
    @(negedge clk_10KHz); #1 reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(negedge clk_10KHz);
      if (bus.push_ack_a || bus.push_ack_b) begin
        who[seen] = bus.push_ack_b ? 1 : 0;
        dat[seen] = bus.q_data;
        seen++;
      end
    end
    #1 bus.push_req_a = 0; bus.push_req_b = 0;
    chk("cont_acks", seen, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("cont%0d", k), {who[k], dat[k]},
          {k % 2, (k % 2) ? 8'h22 : 8'h11});

    // Fill to DEPTH, then a ninth push must stall until a pop.
    do_reset();
    for (int k = 0; k < 8; k++) push_op(k[0], 8'(k + 1), lat, got);
    @(negedge clk_10KHz);
    chk("fill_full", {bus.count, bus.full}, {4'd8, 1'b1});
    #1 bus.push_data_a = 8'hFF; bus.push_req_a = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk_10KHz);
      if (bus.push_ack_a) acks++;
    end
    chk("full_stall", acks, 0);
    pop_op(lat, got);
    chk("full_pop", {lat, got}, {24'd4, 8'h01});
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk_10KHz);
      if (bus.push_ack_a) begin seen = 1; got = bus.q_data; end
    end
    #1 bus.push_req_a = 1'b0;
    chk("ff_ack", {seen, got}, {24'd1, 8'hFF});
    @(negedge clk_10KHz);
    chk("ff_count", bus.count, 4'd8);

    // Tie with pop priority: the pop must finish before the push.
    do_reset();
    push_op(0, 8'h10, lat, got);
    push_op(1, 8'h20, lat, got);
    @(negedge clk_10KHz); #1;
    bus.push_data_a = 8'h99; bus.push_req_a = 1'b1; bus.pop_req = 1'b1;
    first = 0;
    for (int c = 0; c < 20 && first == 0; c++) begin
      @(negedge clk_10KHz);
      if (bus.pop_valid) begin first = 2; got = bus.pop_data; end
      else if (bus.push_ack_a) first = 1;
    end
    #1 bus.pop_req = 1'b0;
    chk("tie_order", {first, got}, {24'd2, 8'h10});
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk_10KHz);
      if (bus.push_ack_a) seen = 1;
    end
    #1 bus.push_req_a = 1'b0;
    chk("tie_push", seen, 1);
    @(negedge clk_10KHz);
    chk("tie_count", bus.count, 4'd2);

    // Reset landing in POP_WAIT.
    do_reset();
    push_op(0, 8'h5A, lat, got);
    @(negedge clk_10KHz); #1 bus.pop_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk_10KHz);
      if (bus.q_dequeue) seen = 1;
    end
    chk("rst_deq_seen", seen, 1);
    @(posedge clk_10KHz); #2 reset = 1'b0;
    #1;
    chk("rst_mid",
        {bus.pop_valid, bus.count, bus.empty,
         bus.q_dequeue, bus.q_enqueue},
        {1'b0, 4'd0, 1'b1, 1'b0, 1'b0});
    bus.pop_req = 1'b0;
    @(negedge clk_10KHz); #1 reset = 1'b1;
    push_op(0, 8'h42, lat, got);
    chk("rst_after_push", {lat, got}, {24'd2, 8'h42});
    pop_op(lat, got);
    chk("rst_after_pop", {lat, got}, {24'd4, 8'h42});

    // Random traffic; the scoreboard checks every cycle.
    do_reset();
    a_busy = 0; b_busy = 0; p_busy = 0;
    a_wait = 0; b_wait = 0; maxw = 0; acks = 0; pops = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_10KHz);
      if (bus.push_ack_a) begin a_busy = 0; acks++; end
      if (bus.push_ack_b) begin b_busy = 0; acks++; end
      if (bus.pop_valid)  begin p_busy = 0; pops++; end
      a_wait = a_busy ? a_wait + 1 : 0;
      b_wait = b_busy ? b_wait + 1 : 0;
      if (a_wait > maxw) maxw = a_wait;
      if (b_wait > maxw) maxw = b_wait;
      #1;
      if (!a_busy && $urandom_range(0, 3) == 0) begin
        a_busy = 1; bus.push_data_a = 8'($urandom);
      end
      if (!b_busy && $urandom_range(0, 3) == 0) begin
        b_busy = 1; bus.push_data_b = 8'($urandom);
      end
      if (!p_busy && $urandom_range(0, 2) == 0) p_busy = 1;
      bus.push_req_a = a_busy;
      bus.push_req_b = b_busy;
      bus.pop_req    = p_busy;
    end
    bus.push_req_a = 0; bus.push_req_b = 0; bus.pop_req = 0;
    repeat (12) @(negedge clk_10KHz);
    chk("rnd_live", maxw < 200, 1);
    chk("rnd_traffic", (acks > 100) && (pops > 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fila_arb.md
Name: fila_arb

Overview:
- Sequencing controller and arbiter in front of the 8-entry `fila` queue (enqueue_in, dequeue_in, data_out, len_out).
- Shares the queue between two producers (A, B) and one consumer.
- Serializes every push and pop into a single queue operation at a time.
- Hides the queue's 2-cycle dequeue latency behind a valid pulse.
- Keeps its own exact occupancy count, because the queue's len_out lags by one cycle.

Parameters:
- DATA_W, 8, data width of the queue entries.
- DEPTH, 8, queue capacity; must match the `fila` instance.
- POP_FIRST, 1, 1 gives pop priority on a push/pop tie; 0 alternates pop and push on ties.

Ports:
- clk_10KHz  input  1  system clock, all state on the rising edge
- reset  input  1  asynchronous, active-low reset
- push_req_a  input  1  producer A holds high until acked
- push_data_a  input  DATA_W  producer A data, stable while push_req_a is high
- push_ack_a  output  1  1-cycle pulse; A's data was enqueued
- push_req_b  input  1  producer B request
- push_data_b  input  DATA_W  producer B data
- push_ack_b  output  1  1-cycle pulse for B
- pop_req  input  1  consumer holds high until pop_valid or until empty
- pop_valid  output  1  1-cycle pulse; pop_data is valid
- pop_data  output  DATA_W  dequeued word, held until the next pop
- q_enqueue  output  1  to fila enqueue_in
- q_dequeue  output  1  to fila dequeue_in
- q_data  output  DATA_W  to fila data_in
- q_rdata  input  DATA_W  from fila data_out
- q_len  input  4  from fila len_out
- count  output  4  exact occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset (reset=0, async): all outputs are 0 except empty=1. State=IDLE, count=0, rr_last=B, so A wins first.
- FSM states: IDLE, PUSH, POP_ISSUE, POP_WAIT, POP_CAPT.
- IDLE:
  - Eligible push: (push_req_a | push_req_b) & !full.
  - Eligible pop: pop_req & !empty.
  - If both are eligible: with POP_FIRST=1 go to POP_ISSUE; with POP_FIRST=0 alternate using a tie flag, pop first after reset.
  - Only push eligible: go to PUSH and latch the grant round-robin. A and B both requesting means grant = opposite of rr_last; a single requester wins.
- PUSH (1 cycle):
  - q_enqueue=1 and q_data = the granted producer's data (registered in IDLE).
  - push_ack_x=1, count+1, rr_last updated, next state IDLE.
- POP_ISSUE (1 cycle): q_dequeue=1 for exactly one cycle, next state POP_WAIT.
- POP_WAIT (1 cycle): q_dequeue=0 while the queue shifts. No enqueue is allowed, since enqueue and shift in the same cycle corrupt the queue. Next state POP_CAPT.
- POP_CAPT (1 cycle): pop_data <= q_rdata, pop_valid=1, count-1, next state IDLE.
- Latency:
  - Push: ack 2 cycles after req is first seen (IDLE, PUSH).
  - Pop: pop_valid in the 4th cycle after req.
  - Back-to-back throughput: one push per 2 cycles, one pop per 4 cycles.
- q_enqueue and q_dequeue are never high together, and neither is high for more than 1 consecutive cycle.
- Full: push requests stall with no ack; a pop still proceeds.
- Empty: pop_req stalls; pop_valid is not asserted.
- Requests that drop before grant are simply forgotten. A request withdrawn after the IDLE-cycle grant is still completed and acked, because its data was already latched.
- full, empty and count are combinational from the registered count.
- Reset mid-operation returns immediately to reset values. The `fila` queue shares the reset event (inverted) so both sides restart empty.

Optional Feature:
- Macro FILA_ARB_CHECK_EN.
- Defined:
  - Adds output len_err (1 bit, sticky until reset).
  - Set when the FSM has been in IDLE for ≥2 consecutive cycles and q_len != count.
- Undefined: no len_err port and no comparison logic; q_len is unused.

Decomposition:
- Package fila_arb_pkg holds:
  - enum state_t {IDLE, PUSH, POP_ISSUE, POP_WAIT, POP_CAPT};
  - constants DEPTH_DEF=8 and CNT_W=4;
  - typedef grant_t {GRANT_A, GRANT_B}.
- One natural sub-module: fila_rr_arb, a 2-way round-robin picker with inputs req[1:0] and last and output grant. Everything else stays in fila_arb.

Test Plan:
- Single push: A pushes 0x3C from empty → q_enqueue in cycle 2, push_ack_a in cycle 2, count=1, empty=0.
- Contention: A (0x11) and B (0x22) held high from reset → acks and enqueues in order A, B, A, B; q_data alternates 0x11/0x22.
- Fill: 8 pushes then a 9th (A=0xFF) → full=1, no ack for 0xFF. Then pop → pop_data = first value; 0xFF is acked afterwards.
- Pop latency: queue holds 0x5A, pop_req=1 → q_dequeue high for 1 cycle only, pop_valid in cycle 4 with pop_data=0x5A, count 1→0.
- Tie with POP_FIRST=1: count=2 and push_req_a and pop_req held high → pop completes first, then push; q_enqueue is never high in POP_WAIT.
- Reset mid-POP_WAIT: drive reset=0 → immediately pop_valid=0, count=0, empty=1, state IDLE. With FILA_ARB_CHECK_EN defined, len_err stays 0 throughout a random push/pop run.
